// File: rtl/ii_pkg.sv
// Shared types, default widths and the saturating-add helper for the integral image generator.
package ii_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned II_W      = 32;
  localparam int unsigned DIM_W     = 16;
  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned MAX_WIDTH = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Adds two w-bit operands (w < 64) and clamps at 2^w-1; bit 64 flags that the clamp fired.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] lim;
    logic [64:0] s;
    lim = (64'(1) << w) - 64'(1);
    s   = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, lim}) return {1'b1, lim};
    return {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/integral_image_gen_if.sv
// Pixel-in / integral-out streaming bus of the integral image generator.
interface integral_image_gen_if #(
  parameter int unsigned PIX_W  = ii_pkg::PIX_W,
  parameter int unsigned II_W   = ii_pkg::II_W,
  parameter int unsigned ADDR_W = ii_pkg::ADDR_W
);
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              ii_valid;
  logic [II_W-1:0]   ii_data;
  logic [ADDR_W-1:0] ii_addr;
  logic              ii_ready;

  modport master (
    output pix_valid, pix_data, ii_ready,
    input  pix_ready, ii_valid, ii_data, ii_addr
  );

  modport slave (
    input  pix_valid, pix_data, ii_ready,
    output pix_ready, ii_valid, ii_data, ii_addr
  );
endinterface

// File: rtl/ii_line_buf.sv
// Single-port previous-row buffer: synchronous write, combinational read at the same index.
module ii_line_buf #(
  parameter  int unsigned DEPTH  = 1024,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];
endmodule

// File: rtl/integral_image_gen.sv
// Raster 8-bit tile to 32-bit summed-area image with linear addresses y*width+x.
// Define II_SAT_EN for saturating arithmetic and the sticky ii_sat flag.
module integral_image_gen #(
  parameter int unsigned PIX_W     = ii_pkg::PIX_W,
  parameter int unsigned II_W      = ii_pkg::II_W,
  parameter int unsigned MAX_WIDTH = ii_pkg::MAX_WIDTH,
  parameter int unsigned DIM_W     = ii_pkg::DIM_W,
  parameter int unsigned ADDR_W    = ii_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  integral_image_gen_if.slave bus,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
`ifdef II_SAT_EN
  ,
  output logic               ii_sat
`endif
);
  import ii_pkg::*;

  localparam int unsigned LB_AW = $clog2(MAX_WIDTH);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  x_q, y_q, width_q, height_q;
  logic [II_W-1:0]   row_sum_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pix_fire, out_fire, start_ok, last_col, last_pix;
  logic [II_W-1:0]   row_base, above, rs, sum, lb_rdata;

  assign bus.pix_ready = (state_q == RUN) && (!bus.ii_valid || bus.ii_ready);
  assign pix_fire      = bus.pix_valid && bus.pix_ready;
  assign out_fire      = bus.ii_valid && bus.ii_ready;
  assign start_ok      = (width != '0) && (width <= DIM_W'(MAX_WIDTH)) && (height != '0);
  assign last_col      = (x_q == width_q - DIM_W'(1));
  assign last_pix      = last_col && (y_q == height_q - DIM_W'(1));
  assign row_base      = (x_q == '0) ? '0 : row_sum_q;
  assign above         = (y_q == '0) ? '0 : lb_rdata;

`ifdef II_SAT_EN
  logic [64:0] add_row, add_col;
  logic        sat_hit;
  logic        unused_sat_hi;

  // Both additions clamp; clamped results leave the upper helper bits at zero.
  always_comb begin
    add_row       = sat_add(64'(row_base), 64'(bus.pix_data), II_W);
    rs            = add_row[II_W-1:0];
    add_col       = sat_add(64'(rs), 64'(above), II_W);
    sum           = add_col[II_W-1:0];
    sat_hit       = add_row[64] | add_col[64];
    unused_sat_hi = ^{add_row[63:II_W], add_col[63:II_W]};
  end
`else
  always_comb begin
    rs  = row_base + II_W'(bus.pix_data);
    sum = rs + above;
  end
`endif

  ii_line_buf #(
    .DEPTH  (MAX_WIDTH),
    .DATA_W (II_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (pix_fire),
    .addr    (LB_AW'(x_q)),
    .wdata   (sum),
    .rdata_c (lb_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && start_ok)     state_d = RUN;
      RUN:     if (pix_fire && last_pix)  state_d = DRAIN;
      DRAIN:   if (out_fire)              state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Counters, output register and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q          <= '0;
      y_q          <= '0;
      width_q      <= '0;
      height_q     <= '0;
      row_sum_q    <= '0;
      addr_q       <= '0;
      bus.ii_valid <= 1'b0;
      bus.ii_data  <= '0;
      bus.ii_addr  <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
`ifdef II_SAT_EN
      ii_sat       <= 1'b0;
`endif
    end else begin
      busy       <= (state_d != IDLE);
      frame_done <= (state_q == DRAIN) && out_fire;

      if (state_q == IDLE && start) begin
        if (start_ok) begin
          width_q   <= width;
          height_q  <= height;
          x_q       <= '0;
          y_q       <= '0;
          row_sum_q <= '0;
          addr_q    <= '0;
`ifdef II_SAT_EN
          ii_sat    <= 1'b0;
`endif
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (pix_fire) begin
        bus.ii_data <= sum;
        bus.ii_addr <= addr_q;
        addr_q      <= addr_q + ADDR_W'(1);
        row_sum_q   <= rs;
        if (last_col) begin
          x_q <= '0;
          y_q <= y_q + DIM_W'(1);
        end else begin
          x_q <= x_q + DIM_W'(1);
        end
`ifdef II_SAT_EN
        if (sat_hit) ii_sat <= 1'b1;
`endif
      end

      if (pix_fire)      bus.ii_valid <= 1'b1;
      else if (out_fire) bus.ii_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed bench for integral_image_gen with hand-computed integral images.
module tb_integral_image_gen;

`ifdef II_SAT_EN
  localparam int unsigned TB_II_W = 16;
`else
  localparam int unsigned TB_II_W = 32;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] width = '0;
  logic [15:0] height = '0;
  logic        busy, frame_done, cfg_err;
`ifdef II_SAT_EN
  logic        ii_sat;
`endif

  always #5 clk = ~clk;

  integral_image_gen_if #(.II_W(TB_II_W)) bus ();

  integral_image_gen #(.II_W(TB_II_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .width      (width),
    .height     (height),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
`ifdef II_SAT_EN
    ,
    .ii_sat     (ii_sat)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int     pix_q[$];
  longint exp_q[$];

  task automatic load(input int pix[], input longint exp[]);
    pix_q.delete();
    exp_q.delete();
    foreach (pix[i]) pix_q.push_back(pix[i]);
    foreach (exp[i]) exp_q.push_back(exp[i]);
  endtask

  // Streams pix_q through a w x h frame and checks every accepted word against exp_q.
  task automatic run_frame(input string tag, input int w, input int h, input bit toggle);
    int n, pi, oi, cyc;
    bit stalled;
    logic [63:0] hold_d, hold_a;
    n = w * h; pi = 0; oi = 0; cyc = 0; stalled = 1'b0;
    hold_d = '0; hold_a = '0;
    @(negedge clk);
    start = 1'b1; width = 16'(w); height = 16'(h);
    @(negedge clk);
    start = 1'b0;
    while (oi < n && cyc < 4000) begin
      @(negedge clk);
      bus.ii_ready  = !toggle || (cyc % 2 == 0);
      bus.pix_valid = (pi < n);
      if (pi < n) bus.pix_data = 8'(pix_q[pi]);
      #1;
      if (bus.ii_valid) begin
        if (stalled) begin
          check({tag, "_hold_data"}, 64'(bus.ii_data), hold_d);
          check({tag, "_hold_addr"}, 64'(bus.ii_addr), hold_a);
        end
        if (bus.ii_ready) begin
          check($sformatf("%s_data%0d", tag, oi), 64'(bus.ii_data), 64'(exp_q[oi]));
          check($sformatf("%s_addr%0d", tag, oi), 64'(bus.ii_addr), 64'(oi));
          oi++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = 64'(bus.ii_data);
          hold_a  = 64'(bus.ii_addr);
        end
      end
      if (bus.pix_valid && bus.pix_ready) pi++;
      cyc++;
    end
    check({tag, "_count"}, 64'(oi), 64'(n));
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #1;
    check({tag, "_done"}, 64'(frame_done), 64'd1);
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    check({tag, "_valid_off"}, 64'(bus.ii_valid), 64'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pi, cyc;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.ii_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("rst_ii_valid", 64'(bus.ii_valid), 64'd0);
    check("rst_ii_data", 64'(bus.ii_data), 64'd0);
    check("rst_ii_addr", 64'(bus.ii_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
`ifdef II_SAT_EN
    check("rst_ii_sat", 64'(ii_sat), 64'd0);
`endif
    reset = 1'b1;

    load('{1, 1, 1, 1, 1, 1, 1, 1, 1}, '{1, 2, 3, 2, 4, 6, 3, 6, 9});
    run_frame("ones3x3", 3, 3, 1'b0);

    load('{255, 255, 255, 255}, '{255, 510, 510, 1020});
    run_frame("max2x2", 2, 2, 1'b0);

    load('{1, 2, 3, 4, 5, 6, 7, 8}, '{1, 3, 6, 10, 6, 14, 24, 36});
    run_frame("stall4x2", 4, 2, 1'b1);

    load('{5, 6, 7}, '{5, 11, 18});
    run_frame("row3x1", 3, 1, 1'b0);

    // Illegal configurations must not leave IDLE.
    @(negedge clk);
    start = 1'b1; width = 16'd0; height = 16'd3;
    @(negedge clk);
    start = 1'b0; bus.pix_valid = 1'b1;
    #1;
    check("w0_cfg_err", 64'(cfg_err), 64'd1);
    check("w0_busy", 64'(busy), 64'd0);
    check("w0_pix_ready", 64'(bus.pix_ready), 64'd0);
    @(negedge clk);
    start = 1'b1; width = 16'd1025; height = 16'd1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("wmax_cfg_err", 64'(cfg_err), 64'd1);
    check("wmax_busy", 64'(busy), 64'd0);
    check("wmax_pix_ready", 64'(bus.pix_ready), 64'd0);
    bus.pix_valid = 1'b0;

    load('{1, 2, 3}, '{1, 3, 6});
    run_frame("col1x3", 1, 3, 1'b0);
    check("col_cfg_err_sticky", 64'(cfg_err), 64'd1);

    // Abort a frame after five pixels, then run a clean one.
    @(negedge clk);
    start = 1'b1; width = 16'd3; height = 16'd3;
    @(negedge clk);
    start = 1'b0; bus.ii_ready = 1'b1;
    pi = 0; cyc = 0;
    while (pi < 5 && cyc < 100) begin
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = 8'd1;
      #1;
      if (bus.pix_ready) pi++;
      cyc++;
    end
    check("abort_fed", 64'(pi), 64'd5);
    @(negedge clk);
    reset = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(bus.ii_valid), 64'd0);
    check("abort_cfg_err", 64'(cfg_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    load('{2, 2, 2, 2, 2, 2, 2, 2, 2}, '{2, 4, 6, 4, 8, 12, 6, 12, 18});
    run_frame("twos3x3", 3, 3, 1'b0);

`ifdef II_SAT_EN
    pix_q.delete();
    exp_q.delete();
    for (int k = 1; k <= 300; k++) begin
      pix_q.push_back(255);
      exp_q.push_back((k * 255 > 65535) ? 65535 : k * 255);
    end
    check("sat_clear", 64'(ii_sat), 64'd0);
    run_frame("sat1x300", 1, 300, 1'b0);
    check("sat_flag", 64'(ii_sat), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/integral_image_gen.md
Name: integral_image_gen

Overview:
- Upstream stage of each face-detection core.
- Converts a raster-ordered 8-bit grayscale tile into a 32-bit integral (summed-area) image: II(x,y) = sum of pixels p(i,j) for i<=x, j<=y.
- Emits each value with its linear address y*width+x, matching the core's image[] addressing (next_row = width), so the core's 4-corner box sums read valid data.
- Streams with valid/ready on both sides and holds one previous row of integral values in a line buffer.

Parameters:
- PIX_W, 8, input pixel width.
- II_W, 32, integral output width.
- MAX_WIDTH, 1024, maximum tile width (line-buffer depth).
- DIM_W, 16, width of the width/height/address-component fields.
- ADDR_W, 20, output address width (covers 100000 entries).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  one-cycle pulse; accepted only in IDLE; latches width/height.
- width  in  DIM_W  tile width in pixels, 1..MAX_WIDTH.
- height  in  DIM_W  tile height in rows, >=1.
- pix_valid  in  1  input pixel valid.
- pix_data  in  PIX_W  pixel value.
- pix_ready  out  1  block can accept a pixel this cycle.
- ii_valid  out  1  output word valid.
- ii_data  out  II_W  integral value.
- ii_addr  out  ADDR_W  linear address y*width+x.
- ii_ready  in  1  consumer accepts the output word.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse after the last word is accepted.
- cfg_err  out  1  sticky flag: start was issued with an illegal width or height.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; x=0, y=0, row_sum=0, addr=0. All outputs 0: pix_ready, ii_valid, ii_data, ii_addr, busy, frame_done, cfg_err. Line-buffer contents are don't-care because row 0 never reads them.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN when start=1 and 1<=width<=MAX_WIDTH and height>=1. On this transition, latch width and height and clear x, y, row_sum and addr.
- An illegal start sets cfg_err and stays in IDLE. cfg_err clears only on reset.
- start is ignored outside IDLE.
- Pixel acceptance: a pixel transfers when pix_valid and pix_ready. pix_ready = (state==RUN) and (!ii_valid or ii_ready). This is a single output register with no skid.
- Per accepted pixel, computed in the same cycle and registered on the next edge (latency 1 cycle from acceptance to ii_valid):
  - rs = (x==0 ? 0 : row_sum) + pix_data.
  - above = (y==0 ? 0 : linebuf[x]).
  - ii_data <= rs + above (II_W arithmetic, modulo 2^II_W).
  - linebuf[x] <= rs + above.
  - row_sum <= rs.
  - ii_addr <= addr, then addr++.
- Counters:
  - x++ per pixel.
  - At x==width-1: x=0, y++.
  - At x==width-1 and y==height-1: go to DRAIN.
- The line buffer is read and written at the same index in one cycle, read-before-write. It is a single-port RAM of depth MAX_WIDTH.
- Output holds: ii_valid stays high and ii_data/ii_addr stay stable until ii_ready=1.
- DRAIN -> IDLE when the final word is accepted. frame_done pulses 1 in the cycle after that acceptance; busy drops in the same cycle.
- width==1: every pixel wraps; II is a column cumulative sum.
- height==1: the line buffer is never read.
- pix_valid held high with ii_ready=0: no pixel is lost and no duplicate is produced.
- Reset mid-frame returns to IDLE immediately. The partial frame is discarded and the next start begins a clean frame.

Optional Feature:
- Macro II_SAT_EN.
- When defined: every addition saturates to 2^II_W-1. A sticky ii_sat output (1 bit, reset 0, cleared on an accepted start) is set on the first saturation.
- When undefined: arithmetic wraps modulo 2^II_W and the ii_sat port does not exist.

Decomposition:
- Shared package ii_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - PIX_W, II_W, DIM_W, ADDR_W defaults;
  - the sat_add helper function.
- One natural sub-module: ii_line_buf, a single-port RAM of MAX_WIDTH x II_W with synchronous write and combinational read.

Test Plan:
1. 3x3 tile, all pixels 1, ii_ready=1 -> ii_data sequence 1,2,3,2,4,6,3,6,9; ii_addr 0..8; single frame_done.
2. 2x2 tile, pixels 255,255,255,255 -> outputs 255,510,510,1020.
3. 4x2 tile, ii_ready toggling 1010 and pix_valid always high -> same values as with ii_ready=1, no drops or duplicates, data stable while stalled.
4. start with width=0, then width=MAX_WIDTH+1 -> cfg_err=1, stays IDLE, pix_ready=0. A following legal start is accepted.
5. reset=0 after 5 pixels of a 3x3 frame, then a new 3x3 frame of all 2s -> outputs 2,4,6,4,8,12,6,12,18; no residue from the aborted frame.
6. With II_SAT_EN: II_W=16, 1x300 tile of 255s -> the value saturates at 65535 from row 257 onward and ii_sat=1.
